load_store_unit: RTL

Byte-addressed CPU-side load/store stage that sits directly upstream of ram_memory and drives its write and read ports. It accepts one request at a time: byte, half or word, load or store, signed or unsigned. It checks alignment and range, runs a read-modify-write for sub-word stores, and sign- or zero-extends load data. It returns a single-cycle response pulse with data or an error flag.

---
 rtl/load_store_unit.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Byte-addressed load/store stage in front of ram_memory. It handles one request at a time,
// runs a read-modify-write for sub-word stores and returns a one-cycle response pulse.
module load_store_unit #(
  parameter int BUS_WIDTH = 32,
  parameter int ADDR_BASE = 10,
  parameter int MEM_SIZE  = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [1:0]           req_size,
  input  logic                 req_unsigned,
  input  logic [BUS_WIDTH-1:0] req_addr,
  input  logic [BUS_WIDTH-1:0] req_wdata,
  output logic                 resp_valid,
  output logic [BUS_WIDTH-1:0] resp_rdata,
  output logic                 resp_error,
  output logic                 ram_write_en,
  output logic [BUS_WIDTH-1:0] ram_addr_write,
  output logic [BUS_WIDTH-1:0] ram_data_write,
  output logic [BUS_WIDTH-1:0] ram_addr_read,
  input  logic [BUS_WIDTH-1:0] ram_data_read,
  input  logic                 ram_ready
);

  localparam logic [BUS_WIDTH-1:0] WADDR_LO = BUS_WIDTH'(ADDR_BASE);
  localparam logic [BUS_WIDTH-1:0] WADDR_HI = BUS_WIDTH'(ADDR_BASE + MEM_SIZE - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WRITE  = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t state, state_next;

  // Request fields captured at acceptance.
  logic                 op_write;
  logic [1:0]           op_size;
  logic                 op_unsigned;
  logic [1:0]           op_lane;
  logic [BUS_WIDTH-1:0] op_waddr;
  logic [15:0]          op_wdata;

  logic [BUS_WIDTH-1:0] waddr;
  logic                 req_error;
  logic                 accept;

  logic                 resp_valid_next;
  logic                 resp_error_next;
  logic [BUS_WIDTH-1:0] resp_rdata_next;
  logic                 ram_write_en_next;
  logic [BUS_WIDTH-1:0] ram_addr_write_next;
  logic [BUS_WIDTH-1:0] ram_data_write_next;
  logic [BUS_WIDTH-1:0] ram_addr_read_next;

  // Replace only the addressed byte or half of the word read back in ACCESS.
  function automatic logic [BUS_WIDTH-1:0] merge_store(
    input logic [BUS_WIDTH-1:0] old_word,
    input logic [1:0]           size,
    input logic [1:0]           lane,
    input logic [15:0]          data
  );
    logic [BUS_WIDTH-1:0] word;
    word = old_word;
    if (size == 2'd0) word[{lane, 3'b000} +: 8] = data[7:0];
    else              word[{lane[1], 4'b0000} +: 16] = data[15:0];
    return word;
  endfunction

  function automatic logic [BUS_WIDTH-1:0] extract_load(
    input logic [BUS_WIDTH-1:0] word,
    input logic [1:0]           size,
    input logic [1:0]           lane,
    input logic                 zero_ext
  );
    logic [BUS_WIDTH-1:0] shifted;
    logic [BUS_WIDTH-1:0] result;
    shifted = word >> {lane, 3'b000};
    case (size)
      2'd0: result = zero_ext ? {{(BUS_WIDTH-8){1'b0}}, shifted[7:0]}
                              : {{(BUS_WIDTH-8){shifted[7]}}, shifted[7:0]};
      2'd1: result = zero_ext ? {{(BUS_WIDTH-16){1'b0}}, shifted[15:0]}
                              : {{(BUS_WIDTH-16){shifted[15]}}, shifted[15:0]};
      default: result = word;
    endcase
    return result;
  endfunction

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;
  assign waddr     = {2'b00, req_addr[BUS_WIDTH-1:2]};

  always_comb begin
    req_error = 1'b0;
    if (req_size == 2'd3)                             req_error = 1'b1;
    if (req_size == 2'd1 && req_addr[0])              req_error = 1'b1;
    if (req_size == 2'd2 && req_addr[1:0] != 2'b00)   req_error = 1'b1;
    if (waddr < WADDR_LO || waddr > WADDR_HI)         req_error = 1'b1;
  end

  // NOTE: every signal assigned here gets a default first so no path leaves one
  // unassigned and infers a latch.
  always_comb begin
    state_next          = state;
    resp_valid_next     = 1'b0;
    resp_error_next     = 1'b0;
    resp_rdata_next     = '0;
    ram_write_en_next   = 1'b0;
    ram_addr_write_next = '0;
    ram_data_write_next = '0;
    ram_addr_read_next  = '0;

    case (state)
      IDLE: begin
        if (accept) begin
          if (req_error) begin
            state_next      = RESP;
            resp_valid_next = 1'b1;
            resp_error_next = 1'b1;
          end else if (req_write && req_size == 2'd2) begin
            state_next          = WRITE;
            ram_write_en_next   = 1'b1;
            ram_addr_write_next = waddr;
            ram_data_write_next = req_wdata;
          end else begin
            state_next         = ACCESS;
            ram_addr_read_next = waddr;
          end
        end
      end

      ACCESS: begin
        if (!ram_ready) begin
          state_next      = RESP;
          resp_valid_next = 1'b1;
          resp_error_next = 1'b1;
        end else if (op_write) begin
          state_next          = WRITE;
          ram_write_en_next   = 1'b1;
          ram_addr_write_next = op_waddr;
          ram_data_write_next = merge_store(ram_data_read, op_size, op_lane, op_wdata);
        end else begin
          state_next      = RESP;
          resp_valid_next = 1'b1;
          resp_rdata_next = extract_load(ram_data_read, op_size, op_lane, op_unsigned);
        end
      end

      WRITE: begin
        state_next      = RESP;
        resp_valid_next = 1'b1;
      end

      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_write    <= 1'b0;
      op_size     <= 2'd0;
      op_unsigned <= 1'b0;
      op_lane     <= 2'd0;
      op_waddr    <= '0;
      op_wdata    <= '0;
    end else if (accept) begin
      op_write    <= req_write;
      op_size     <= req_size;
      op_unsigned <= req_unsigned;
      op_lane     <= req_addr[1:0];
      op_waddr    <= waddr;
      op_wdata    <= req_wdata[15:0];
    end
  end

  // All outputs except req_ready are registered so reset clears them immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_valid     <= 1'b0;
      resp_error     <= 1'b0;
      resp_rdata     <= '0;
      ram_write_en   <= 1'b0;
      ram_addr_write <= '0;
      ram_data_write <= '0;
      ram_addr_read  <= '0;
    end else begin
      resp_valid     <= resp_valid_next;
      resp_error     <= resp_error_next;
      resp_rdata     <= resp_rdata_next;
      ram_write_en   <= ram_write_en_next;
      ram_addr_write <= ram_addr_write_next;
      ram_data_write <= ram_data_write_next;
      ram_addr_read  <= ram_addr_read_next;
    end
  end

endmodule
